mult_bus_master: RTL
====================

Name: mult_bus_master

Overview:
- Host-side controller that drives the shift-add multiplier's external bus protocol end to end.
- Sequence: load operand M (func 00), load operand Q (func 01), hold the active-low start line long enough to pass the multiplier's debounce, wait for completion on ready, then read the low byte (func 10, oe) and the high byte (func 11, oe).
- Sits directly upstream of the multiplier, on the same oscillator clock.
- Presents a simple req/done handshake to the rest of the design.

Parameters:
- N, 8: operand width; equals the multiplier's n.
- START_HOLD, 4000: cycles start_n is held low, and then held high, per operation. Must exceed the multiplier debounce length (freq/1000 = 3330).
- TIMEOUT, 65535: maximum cycles from start assertion to completion before an error is declared.
- SETTLE, 2: cycles oe/func are held before each read byte is captured.

Ports:
- clock  in  1  system clock, same as multiplier osc_clk
- reset  in  1  synchronous, active-high
- req  in  1  start request; accepted only in IDLE
- op_a  in  N  multiplicand (loaded as M)
- op_b  in  N  multiplier (loaded as Q)
- busy  out  1  high from accept until done
- done  out  1  one-cycle pulse at end of operation (success or timeout)
- product  out  2N  result; valid while done=1 and held until the next accept
- timeout_err  out  1  sticky error flag; cleared on the next accept
- mult_func  out  2  multiplier func select
- mult_oe  out  1  multiplier output enable
- mult_start_n  out  1  to multiplier startPB (active-low)
- mult_ready  in  1  multiplier ready
- mult_data  inout  N  shared bidirectional data bus

Behaviour:
- Reset (synchronous, takes priority in every state):
  - State returns to IDLE.
  - Outputs: mult_func=10, mult_oe=0, mult_start_n=1, mult_data=Z, busy=0, done=0, product=0, timeout_err=0.
  - A reset mid-operation aborts immediately; the multiplier bus is released on the next edge.
- Park condition: func=10 with oe=0. This neither loads nor drives on the multiplier side. The master parks here in IDLE and in every state where it is not loading or reading.
- Bus drive rule: mult_data is driven only in LOAD_M and LOAD_Q, and only while mult_oe=0. It is Z otherwise.
- mult_oe=1 and a driven mult_data never coincide in any cycle.
- FSM (one transition per clock edge):
  - IDLE: on req=1, latch op_a/op_b, set busy=1, clear timeout_err, go to LOAD_M. req while busy is ignored.
  - LOAD_M (2 cycles): func=00, drive op_a.
  - LOAD_Q (2 cycles): func=01, drive op_b.
  - PARK (1 cycle): func=10, bus Z. Clear seen_busy; zero the timeout counter.
  - START (START_HOLD cycles): start_n=0.
  - RELEASE (START_HOLD cycles): start_n=1.
  - WAIT: exit to READ_LO when seen_busy=1 and mult_ready=1.
  - READ_LO (SETTLE cycles): func=10, oe=1. Capture product[N-1:0] from mult_data on the last cycle.
  - TURN (1 cycle): oe=0.
  - READ_HI (SETTLE cycles): func=11, oe=1. Capture product[2N-1:N] on the last cycle.
  - FINISH (1 cycle): oe=0, func=10, done=1, busy=0, then go to IDLE.
- seen_busy:
  - Set on any cycle in START, RELEASE or WAIT where mult_ready=0.
  - This makes a ready-low phase that starts during START or RELEASE count toward completion.
- Timeout:
  - The counter runs from entry to START until WAIT exits.
  - When it reaches TIMEOUT: go to FINISH with timeout_err=1, product=0, and skip both reads.
  - If completion and timeout occur in the same cycle, completion wins.
- Latency on the success path:
  - From accept to done = 2+2+1+2·START_HOLD+(WAIT cycles)+SETTLE+1+SETTLE+1 cycles.
  - With defaults and WAIT=0, that is 8011 cycles.
- product and timeout_err hold their values in IDLE.

Test Plan:
- Bench setup for all scenarios: behavioural multiplier model with start debounce of 8 cycles; bench parameters START_HOLD=10, TIMEOUT=200.
- op_a=13, op_b=11, req pulse:
  - Model sees M=13 and Q=11; start_n is low for exactly 10 cycles.
  - Reads occur as func 10 then 11, each with oe=1.
  - done pulses once; product=0x008F; timeout_err=0.
- op_a=255, op_b=255:
  - product=0xFE01.
  - Across the entire run, mult_data is never driven while mult_oe=1 (assertion).
- op_a=0, op_b=0xA5:
  - product=0x0000.
  - Separately, ready drops during START (model with debounce 4): completion is still detected, and product is correct.
- Model ready stuck at 1:
  - done occurs 200 cycles after START entry, with timeout_err=1 and product=0.
  - The next req clears timeout_err.
- reset asserted for 1 cycle mid-START:
  - On the next edge: start_n=1, func=10, oe=0, bus Z, busy=0.
  - No done pulse.
- req held high through an operation:
  - A second operation begins only after FINISH returns to IDLE.
  - Operands are the values latched at the first accept, even if op_a changes mid-operation.

Source files
------------

// File: rtl/mult_bus_master.sv
// Host-side sequencer for the shift-add multiplier bus: loads M and Q,
// holds startPB low past the debounce, waits for ready, reads both bytes.
//
// Ports:
//   clock, reset       system clock (multiplier osc_clk), sync active-high reset
//   req                start request, accepted only when idle
//   op_a, op_b         operands, latched on accept (loaded as M and Q)
//   busy, done         busy from accept to done; done is a one-cycle pulse
//   product            2N-bit result, valid with done, held until next accept
//   timeout_err        sticky, set when the multiplier never completes
//   mult_func, mult_oe function select and output enable to the multiplier
//   mult_start_n       active-low start (startPB)
//   mult_ready         multiplier ready
//   mult_data          shared bidirectional data bus
`timescale 1ns/1ps
module mult_bus_master #(
    parameter int N          = 8,
    parameter int START_HOLD = 4000,
    parameter int TIMEOUT    = 65535,
    parameter int SETTLE     = 2
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           req,
    input  logic [N-1:0]   op_a,
    input  logic [N-1:0]   op_b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] product,
    output logic           timeout_err,
    output logic [1:0]     mult_func,
    output logic           mult_oe,
    output logic           mult_start_n,
    input  logic           mult_ready,
    inout  wire  [N-1:0]   mult_data
);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_M,
        S_LOAD_Q,
        S_PARK,
        S_START,
        S_RELEASE,
        S_WAIT,
        S_READ_LO,
        S_TURN,
        S_READ_HI,
        S_FINISH
    } state_t;

    localparam logic [1:0]  F_LOAD_M = 2'b00;
    localparam logic [1:0]  F_LOAD_Q = 2'b01;
    localparam logic [1:0]  F_PARK   = 2'b10;
    localparam logic [1:0]  F_HI     = 2'b11;

    localparam logic [31:0] HOLD_LAST   = 32'(START_HOLD - 1);
    localparam logic [31:0] SETTLE_LAST = 32'(SETTLE - 1);
    localparam logic [31:0] TMO_LAST    = 32'(TIMEOUT - 1);

    state_t         r_state;
    logic [31:0]    r_cnt;
    logic [31:0]    r_tmo;
    logic           r_seen_busy;
    logic           r_drive;
    logic           r_oe;
    logic           r_start_n;
    logic           r_busy;
    logic           r_done;
    logic           r_tmo_err;
    logic [1:0]     r_func;
    logic [N-1:0]   r_dout;
    logic [N-1:0]   r_opb;
    logic [2*N-1:0] r_product;

    logic w_hold_last;
    logic w_settle_last;
    logic w_tmo_hit;
    logic w_complete;
    logic w_in_run;
    logic w_go_read;
    logic w_go_tmo;

    assign w_hold_last   = (r_cnt == HOLD_LAST);
    assign w_settle_last = (r_cnt == SETTLE_LAST);
    assign w_tmo_hit     = (r_tmo == TMO_LAST);
    assign w_complete    = r_seen_busy & mult_ready;

    assign w_in_run = (r_state == S_START) ||
                      (r_state == S_RELEASE) ||
                      (r_state == S_WAIT);

    // Completion may be taken on the last RELEASE cycle, so a
    // zero-length WAIT is possible; completion beats timeout.
    assign w_go_read = (r_state == S_WAIT && w_complete) ||
                       (r_state == S_RELEASE && w_hold_last && w_complete);
    assign w_go_tmo  = w_in_run && w_tmo_hit && !w_go_read;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_seen_busy <= 1'b0;
            r_drive     <= 1'b0;
            r_oe        <= 1'b0;
            r_start_n   <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_tmo_err   <= 1'b0;
            r_func      <= F_PARK;
            r_dout      <= '0;
            r_opb       <= '0;
            r_product   <= '0;
        end else begin
            r_done <= 1'b0;
            r_cnt  <= r_cnt + 32'd1;

            if (w_in_run) begin
                r_tmo <= r_tmo + 32'd1;
                if (!mult_ready)
                    r_seen_busy <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_state   <= S_LOAD_M;
                        r_dout    <= op_a;
                        r_opb     <= op_b;
                        r_busy    <= 1'b1;
                        r_tmo_err <= 1'b0;
                        r_func    <= F_LOAD_M;
                        r_drive   <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                S_LOAD_M: begin
                    if (r_cnt == 32'd1) begin
                        r_state <= S_LOAD_Q;
                        r_func  <= F_LOAD_Q;
                        r_dout  <= r_opb;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD_Q: begin
                    if (r_cnt == 32'd1) begin
                        r_state <= S_PARK;
                        r_func  <= F_PARK;
                        r_drive <= 1'b0;
                        r_cnt   <= '0;
                    end
                end
                S_PARK: begin
                    r_state     <= S_START;
                    r_start_n   <= 1'b0;
                    r_seen_busy <= 1'b0;
                    r_tmo       <= '0;
                    r_cnt       <= '0;
                end
                S_START: begin
                    if (w_hold_last) begin
                        r_state   <= S_RELEASE;
                        r_start_n <= 1'b1;
                        r_cnt     <= '0;
                    end
                end
                S_RELEASE: begin
                    if (w_hold_last)
                        r_state <= S_WAIT;
                end
                S_WAIT: begin
                    r_state <= S_WAIT;
                end
                S_READ_LO: begin
                    if (w_settle_last) begin
                        r_product[N-1:0] <= mult_data;
                        r_state          <= S_TURN;
                        r_oe             <= 1'b0;
                    end
                end
                S_TURN: begin
                    r_state <= S_READ_HI;
                    r_func  <= F_HI;
                    r_oe    <= 1'b1;
                    r_cnt   <= '0;
                end
                S_READ_HI: begin
                    if (w_settle_last) begin
                        r_product[2*N-1:N] <= mult_data;
                        r_state            <= S_FINISH;
                        r_oe               <= 1'b0;
                        r_func             <= F_PARK;
                        r_done             <= 1'b1;
                        r_busy             <= 1'b0;
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase

            // Exits from the start/wait window override the case above.
            if (w_go_read) begin
                r_state   <= S_READ_LO;
                r_start_n <= 1'b1;
                r_func    <= F_PARK;
                r_oe      <= 1'b1;
                r_cnt     <= '0;
            end else if (w_go_tmo) begin
                r_state   <= S_FINISH;
                r_start_n <= 1'b1;
                r_func    <= F_PARK;
                r_oe      <= 1'b0;
                r_tmo_err <= 1'b1;
                r_product <= '0;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
            end
        end
    end

    // Drive only while loading; oe gating keeps the bus free during reads.
    assign mult_data    = (r_drive && !r_oe) ? r_dout : {N{1'bz}};
    assign mult_func    = r_func;
    assign mult_oe      = r_oe;
    assign mult_start_n = r_start_n;
    assign busy         = r_busy;
    assign done         = r_done;
    assign product      = r_product;
    assign timeout_err  = r_tmo_err;

endmodule
